fifo_clk_scheduler: RTL

//  Sequences the 12-bit instruction FIFO into the execution unit and picks the

---
 rtl/fifo_clk_scheduler_if.sv | 37 +++
 rtl/fifo_clk_scheduler.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fifo_clk_scheduler_if.sv
// Bundle between the instruction FIFO, the scheduler and the execution unit.
//   fifo_counter  FIFO occupancy
//   data_empty    FIFO empty flag
//   data_full     FIFO full flag
//   data_out      FIFO read data, valid the cycle after rd_en
//   rd_en         FIFO pop request, single-cycle pulse
//   ex_valid      instruction offered to the execution unit
//   ex_instr      instruction held for the execution unit
//   ex_ready      execution unit accepts ex_instr
//   select        divider select: 00 gated, 01 div4, 10 div2, 11 div1
//   busy          scheduler is not idle
// master = scheduler side, slave = FIFO/execution-unit/divider side.
interface fifo_clk_scheduler_if #(
    parameter int DW = 12,
    parameter int CW = 8
);
    logic [CW-1:0] fifo_counter;
    logic          data_empty;
    logic          data_full;
    logic [DW-1:0] data_out;
    logic          rd_en;
    logic          ex_valid;
    logic [DW-1:0] ex_instr;
    logic          ex_ready;
    logic [1:0]    select;
    logic          busy;

    modport master (
        input  fifo_counter, data_empty, data_full, data_out, ex_ready,
        output rd_en, ex_valid, ex_instr, select, busy
    );

    modport slave (
        output fifo_counter, data_empty, data_full, data_out, ex_ready,
        input  rd_en, ex_valid, ex_instr, select, busy
    );
endinterface

// File: rtl/fifo_clk_scheduler.sv
// Pops the instruction FIFO one entry at a time, hands each instruction to
// the execution unit over a valid/ready handshake, and picks the divider
// rate from FIFO occupancy with hysteresis and idle clock gating.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous reset, active-low
//   bus   fifo_clk_scheduler_if.master (FIFO, execution unit, divider select)
module fifo_clk_scheduler #(
    parameter int DW      = 12,
    parameter int CW      = 8,
    parameter int HI_TH   = 6,
    parameter int LO_TH   = 2,
    parameter int HOLD    = 4,
    parameter int IDLE_TO = 16
) (
    input logic                  clk,
    input logic                  rst,
    fifo_clk_scheduler_if.master bus
);
    localparam int HW = $clog2(HOLD + 1);
    localparam int IW = $clog2(IDLE_TO + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TO);
    localparam logic [CW-1:0] HI_LVL   = CW'(HI_TH);
    localparam logic [CW-1:0] LO_LVL   = CW'(LO_TH);

    typedef enum logic [1:0] {IDLE, POP, CAPT, ISSUE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          rd_en;
    logic          busy;
    logic          ex_valid;
    logic [DW-1:0] ex_instr;
    logic [1:0]    sel;
    logic [1:0]    sel_nxt;
    logic [1:0]    target;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] idle_cnt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!bus.data_empty) state_nxt = POP;
            POP:   state_nxt = bus.data_empty ? IDLE : CAPT;
            CAPT:  state_nxt = ISSUE;
            ISSUE: if (ex_valid && bus.ex_ready)
                       state_nxt = bus.data_empty ? IDLE : POP;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; the pop is suppressed if the FIFO empties while in POP
    always_comb begin
        rd_en = (state == POP) && !bus.data_empty;
        busy  = (state != IDLE);
    end

    // Instruction hand-over register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_instr <= '0;
        end else if (state == CAPT) begin
            ex_valid <= 1'b1;
            ex_instr <= bus.data_out;
        end else if (state == ISSUE && ex_valid && bus.ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // Consecutive empty cycles spent in IDLE, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               idle_cnt <= '0;
        else if (state != IDLE || !bus.data_empty) idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX)          idle_cnt <= idle_cnt + 1'b1;
    end

    // Rate target; gating is only possible from IDLE, so select never
    // reaches 00 while busy
    always_comb begin
        if (state == IDLE && bus.data_empty && idle_cnt == IDLE_MAX)
            target = 2'b00;
        else if (bus.fifo_counter >= HI_LVL || bus.data_full)
            target = 2'b11;
        else if (bus.fifo_counter > LO_LVL)
            target = 2'b10;
        else
            target = 2'b01;
    end

    // Full and wake-from-gated bypass the hold interval; otherwise step one
    // level toward the target once the hold counter has saturated
    always_comb begin
        sel_nxt = sel;
        if (bus.data_full)
            sel_nxt = 2'b11;
        else if (sel == 2'b00 && !bus.data_empty)
            sel_nxt = 2'b01;
        else if (hold_cnt == HOLD_MAX && sel != target)
            sel_nxt = (target > sel) ? sel + 2'd1 : sel - 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel      <= 2'b01;
            hold_cnt <= '0;
        end else begin
            sel <= sel_nxt;
            if (sel_nxt != sel)          hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign bus.rd_en    = rd_en;
    assign bus.busy     = busy;
    assign bus.ex_valid = ex_valid;
    assign bus.ex_instr = ex_instr;
    assign bus.select   = sel;
endmodule
